// File: rtl/wb_gpio_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_gpio_irq_pkg
// Purpose  : Shared constants for the Wishbone GPIO block: register word
//            indices, debounce sample count, bus ack latency and a byte-lane
//            mask helper.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package wb_gpio_irq_pkg;

    localparam logic [3:0] REG_DATA_IN    = 4'd0;
    localparam logic [3:0] REG_DATA_OUT   = 4'd1;
    localparam logic [3:0] REG_DIR        = 4'd2;
    localparam logic [3:0] REG_OUT_SET    = 4'd3;
    localparam logic [3:0] REG_OUT_CLR    = 4'd4;
    localparam logic [3:0] REG_RISE_EN    = 4'd5;
    localparam logic [3:0] REG_FALL_EN    = 4'd6;
    localparam logic [3:0] REG_IRQ_STATUS = 4'd7;
    localparam logic [3:0] REG_DEBOUNCE   = 4'd8;

    // Consecutive prescaler ticks that must agree before a pin's debounced
    // value follows the synchronised input.
    localparam int DEBOUNCE_SAMPLES = 3;

    // Wait states inserted by the registered acknowledge.
    localparam int ACK_LATENCY = 1;

    // Expand the four byte enables into a 32-bit write mask.
    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_gpio_irq_gpio_in_cond.sv
`default_nettype none
// ============================================================================
// Module   : gpio_in_cond
// Purpose  : Input conditioning for a vector of asynchronous pins:
//            SYNC_STAGES-deep synchroniser, optional tick-based debounce
//            (GPIO_DEBOUNCE_EN) and a previous-sample register for edge
//            detection.
// Ports    : clk_i, rst_i        clock, asynchronous active-high reset
//            gpio_i             raw pin inputs
//            deb_period_i       prescaler reload value   (GPIO_DEBOUNCE_EN)
//            deb_load_i         reload prescaler now     (GPIO_DEBOUNCE_EN)
//            value_o            conditioned pin value
//            rise_o / fall_o    unmasked rising / falling edge pulses
// Revision : 1.0  initial release
// ============================================================================
module gpio_in_cond
    import wb_gpio_irq_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] gpio_i,
`ifdef GPIO_DEBOUNCE_EN
    input  logic [15:0]      deb_period_i,
    input  logic             deb_load_i,
`endif
    output logic [WIDTH-1:0] value_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] cond;
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    logic [15:0] presc_q;
    logic        tick;

    // Tick when the prescaler hits zero; DEBOUNCE=0 therefore ticks every cycle.
    assign tick = (presc_q == 16'd0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                   presc_q <= 16'd0;
        else if (deb_load_i || tick) presc_q <= deb_period_i;
        else                         presc_q <= presc_q - 16'd1;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        logic [1:0] hits_q;
        logic       deb_q;

        // hits_q counts consecutive ticks that saw the opposite of deb_q;
        // any agreeing tick restarts the count.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                hits_q <= 2'd0;
                deb_q  <= 1'b0;
            end else if (tick) begin
                if (sync_s[i] == deb_q) begin
                    hits_q <= 2'd0;
                end else if (hits_q == 2'(DEBOUNCE_SAMPLES - 1)) begin
                    hits_q <= 2'd0;
                    deb_q  <= sync_s[i];
                end else begin
                    hits_q <= hits_q + 2'd1;
                end
            end
        end

        assign cond[i] = deb_q;
    end
`else
    assign cond = sync_s;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) prev_q <= '0;
        else       prev_q <= cond;
    end

    assign value_o = cond;
    assign rise_o  =  cond & ~prev_q;
    assign fall_o  = ~cond &  prev_q;

endmodule
`default_nettype wire

// File: rtl/wb_gpio_irq.sv
`default_nettype none
// ============================================================================
// Module   : wb_gpio_irq
// Purpose  : Wishbone classic GPIO slave, 1..32 pins, synchronised inputs,
//            atomic set/clear of outputs, per-pin rise/fall edge detection
//            with W1C status and one level interrupt. Optional input
//            debounce is built when GPIO_DEBOUNCE_EN is defined.
// Ports    : wb_clk_i, wb_rst_i   clock, asynchronous active-high reset
//            wb_adr_i..wb_stb_i   Wishbone slave inputs (word address [5:2])
//            wb_dat_o, wb_ack_o   registered read data / acknowledge
//            gpio_i               asynchronous pin inputs
//            gpio_o, gpio_dir_o   registered pin outputs / output enables
//            irq_o                registered OR of IRQ_STATUS
// Revision : 1.0  initial release
// ============================================================================
module wb_gpio_irq
    import wb_gpio_irq_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [3:0]       wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    input  logic [3:0]       wb_sel_i,
    input  logic             wb_we_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_dir_o,
    output logic             irq_o
);

    logic             ack_q;
    logic [31:0]      dat_q, dat_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] ren_q, ren_d;
    logic [WIDTH-1:0] fen_q, fen_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0] clr;
    logic             irq_q;

    logic             acc_en, wr_en;
    logic [31:0]      wmask, wdat_m;
    logic [WIDTH-1:0] wmask_w, wdat_w;
    logic [WIDTH-1:0] din, rise, fall;
    logic [31:0]      rdata;

    // An access is serviced only on the cycle before ack rises, which makes
    // every access exactly one wait state and keeps acks from abutting.
    assign acc_en  = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr_en   = acc_en & wb_we_i;
    assign wmask   = byte_mask(wb_sel_i);
    assign wdat_m  = wb_dat_i & wmask;
    assign wmask_w = wmask[WIDTH-1:0];
    assign wdat_w  = wdat_m[WIDTH-1:0];

`ifdef GPIO_DEBOUNCE_EN
    logic [15:0] deb_q, deb_d;
    logic        deb_load;

    assign deb_load = wr_en && (wb_adr_i == REG_DEBOUNCE);

    gpio_in_cond #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_in_cond (
        .clk_i        (wb_clk_i),
        .rst_i        (wb_rst_i),
        .gpio_i       (gpio_i),
        .deb_period_i (deb_d),
        .deb_load_i   (deb_load),
        .value_o      (din),
        .rise_o       (rise),
        .fall_o       (fall)
    );
`else
    gpio_in_cond #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_in_cond (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .gpio_i  (gpio_i),
        .value_o (din),
        .rise_o  (rise),
        .fall_o  (fall)
    );
`endif

    always_comb begin
        out_d = out_q;
        dir_d = dir_q;
        ren_d = ren_q;
        fen_d = fen_q;
        clr   = '0;
`ifdef GPIO_DEBOUNCE_EN
        deb_d = deb_q;
`endif
        if (wr_en) begin
            case (wb_adr_i)
                REG_DATA_OUT:   out_d = (out_q & ~wmask_w) | wdat_w;
                REG_DIR:        dir_d = (dir_q & ~wmask_w) | wdat_w;
                REG_OUT_SET:    out_d = out_q | wdat_w;
                REG_OUT_CLR:    out_d = out_q & ~wdat_w;
                REG_RISE_EN:    ren_d = (ren_q & ~wmask_w) | wdat_w;
                REG_FALL_EN:    fen_d = (fen_q & ~wmask_w) | wdat_w;
                REG_IRQ_STATUS: clr   = wdat_w;
`ifdef GPIO_DEBOUNCE_EN
                REG_DEBOUNCE:   deb_d = (deb_q & ~wmask[15:0]) | wdat_m[15:0];
`endif
                default: ;
            endcase
        end
        // A new edge in the same cycle as a W1C clear keeps the bit set.
        status_d = (status_q & ~clr) | (rise & ren_q) | (fall & fen_q);
    end

    always_comb begin
        rdata = 32'd0;
        case (wb_adr_i)
            REG_DATA_IN:    rdata = 32'(din);
            REG_DATA_OUT:   rdata = 32'(out_q);
            REG_DIR:        rdata = 32'(dir_q);
            REG_RISE_EN:    rdata = 32'(ren_q);
            REG_FALL_EN:    rdata = 32'(fen_q);
            REG_IRQ_STATUS: rdata = 32'(status_q);
`ifdef GPIO_DEBOUNCE_EN
            REG_DEBOUNCE:   rdata = 32'(deb_q);
`endif
            default:        rdata = 32'd0;
        endcase
        dat_d = (acc_en && !wb_we_i) ? rdata : 32'd0;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            dat_q    <= 32'd0;
            out_q    <= RESET_OUT;
            dir_q    <= RESET_DIR;
            ren_q    <= '0;
            fen_q    <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            ack_q    <= acc_en;
            dat_q    <= dat_d;
            out_q    <= out_d;
            dir_q    <= dir_d;
            ren_q    <= ren_d;
            fen_q    <= fen_d;
            status_q <= status_d;
            irq_q    <= |status_q;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) deb_q <= 16'd0;
        else          deb_q <= deb_d;
    end
`endif

    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = dat_q;
    assign gpio_o     = out_q;
    assign gpio_dir_o = dir_q;
    assign irq_o      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_gpio_irq.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_gpio_irq
// Purpose  : Self-checking bench for wb_gpio_irq (12 pins, 2 sync stages),
//            directed timing steps plus randomized register/pin traffic
//            checked against a register-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_gpio_irq;

    localparam int          W  = 12;
    localparam int          S  = 2;
    localparam logic [W-1:0] R_OUT = 12'h0A5;
    localparam logic [W-1:0] R_DIR = 12'h00F;
    localparam logic [31:0] M  = 32'h0000_0FFF;
`ifdef GPIO_DEBOUNCE_EN
    localparam int EXTRA = 3;
`else
    localparam int EXTRA = 0;
`endif
    localparam int SETTLE = 12;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   adr;
    logic [31:0]  dat_i;
    logic [3:0]   sel;
    logic         we, cyc, stb;
    logic [31:0]  dat_o;
    logic         ack;
    logic [W-1:0] gpio, gpio_o, gpio_dir;
    logic         irq;

    int n_checks = 0;
    int n_err    = 0;

    // model state
    logic [31:0] m_out, m_dir, m_re, m_fe, m_st, m_in, m_deb;

    wb_gpio_irq #(
        .WIDTH(W), .SYNC_STAGES(S), .RESET_OUT(R_OUT), .RESET_DIR(R_DIR)
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i),
        .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
        .wb_dat_o(dat_o), .wb_ack_o(ack), .gpio_i(gpio), .gpio_o(gpio_o),
        .gpio_dir_o(gpio_dir), .irq_o(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = s[b] ? 8'hFF : 8'h00;
        return r;
    endfunction

    function automatic logic [31:0] exp_read(input logic [3:0] a);
        case (a)
            4'd0: return m_in;
            4'd1: return m_out;
            4'd2: return m_dir;
            4'd5: return m_re;
            4'd6: return m_fe;
            4'd7: return m_st;
`ifdef GPIO_DEBOUNCE_EN
            4'd8: return m_deb;
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic bus(input logic w, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd);
        chk("ack_idle", 32'(ack), 32'd0);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        tick();
        chk("ack_rise", 32'(ack), 32'd1);
        rd = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
        chk("ack_fall", 32'(ack), 32'd0);
        chk("dat_idle", dat_o, 32'd0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd, bm, dm;
        bm = bmask(s);
        dm = d & bm;
        case (a)
            4'd1: m_out = ((m_out & ~bm) | dm) & M;
            4'd2: m_dir = ((m_dir & ~bm) | dm) & M;
            4'd3: m_out = (m_out | dm) & M;
            4'd4: m_out = m_out & ~dm;
            4'd5: m_re  = ((m_re & ~bm) | dm) & M;
            4'd6: m_fe  = ((m_fe & ~bm) | dm) & M;
            4'd7: m_st  = m_st & ~dm;
`ifdef GPIO_DEBOUNCE_EN
            4'd8: m_deb = ((m_deb & ~bm) | dm) & 32'h0000_FFFF;
`endif
            default: ;
        endcase
        bus(1'b1, a, d, s, rd);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a);
        logic [31:0] rd;
        bus(1'b0, a, 32'd0, 4'hF, rd);
        chk(tag, rd, exp_read(a));
    endtask

    // Change the pins, let them settle, then account for any enabled edges.
    task automatic drive_pin(input logic [W-1:0] v);
        logic [31:0] nv, ov;
        nv = 32'(v);
        ov = 32'(gpio);
        m_st = m_st | (nv & ~ov & m_re) | (~nv & ov & m_fe);
        gpio = v;
        tick_n(SETTLE);
        m_in = nv;
        chk("irq_level", 32'(irq), 32'(m_st != 0));
    endtask

    task automatic model_reset();
        m_out = 32'(R_OUT); m_dir = 32'(R_DIR);
        m_re = 0; m_fe = 0; m_st = 0; m_deb = 0;
    endtask

    initial begin
        logic [3:0] a;
        int op;

        rst = 1'b1; adr = 0; dat_i = 0; sel = 0; we = 0; cyc = 0; stb = 0;
        gpio = '0;
        model_reset();
        m_in = 0;
        tick_n(3);
        rst = 1'b0;
        tick();

        // reset state
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_gpio_o", 32'(gpio_o), 32'h0A5);
        chk("rst_dir_o", 32'(gpio_dir), 32'h00F);
        for (int i = 0; i < 16; i++) rd_chk("rst_read", 4'(i));

        // set / clear outputs through byte lane 0 only
        wr(4'd1, 32'h0000_00F0, 4'b0001);
        wr(4'd3, 32'h0000_0003, 4'b0001);
        wr(4'd4, 32'h0000_0010, 4'b0001);
        chk("setclr_gpio_o", 32'(gpio_o), 32'h0E3);
        chk("setclr_model", 32'(gpio_o), m_out);
        rd_chk("setclr_rd_out", 4'd1);
        rd_chk("setclr_rd_set", 4'd3);
        rd_chk("setclr_rd_clr", 4'd4);

        // rising edge latency on pin 0
        wr(4'd5, 32'h1, 4'hF);
        gpio[0] = 1'b1;
        m_st = m_st | 32'h1;
        tick_n(2 + EXTRA);
        chk("rise_irq_early", 32'(irq), 32'd0);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 4'd0;
        tick();
        chk("rise_rd_ack", 32'(ack), 32'd1);
        chk("rise_data_in", dat_o, 32'h1);
        chk("rise_irq_status_cyc", 32'(irq), 32'd0);
        cyc = 1'b0; stb = 1'b0;
        tick();
        chk("rise_irq_set", 32'(irq), 32'd1);
        m_in = 32'h1;
        tick_n(SETTLE);
        rd_chk("rise_status", 4'd7);
        wr(4'd7, 32'h1, 4'hF);
        chk("w1c_irq_fall", 32'(irq), 32'd0);
        rd_chk("w1c_status", 4'd7);

        // W1C coinciding with a fall on pin 1: set wins
        wr(4'd6, 32'h2, 4'hF);
        drive_pin(gpio | 12'h002);
        drive_pin(gpio & ~12'h002);
        drive_pin(gpio | 12'h002);
        gpio[1] = 1'b0;
        tick_n(2 + EXTRA);
        wr(4'd7, 32'h2, 4'hF);
        m_st = m_st | 32'h2;
        m_in = 32'(gpio);
        tick_n(SETTLE);
        rd_chk("coincide_status", 4'd7);
        chk("coincide_irq", 32'(irq), 32'd1);

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 3);
            if (op == 0) begin
                a = 4'($urandom_range(0, 15));
                if (a == 4'd8) a = 4'd9;
                wr(a, $urandom, 4'($urandom));
            end else if (op == 1) begin
                a = 4'($urandom_range(1, 6));
                wr(a, $urandom, 4'hF);
            end else if (op == 2) begin
                drive_pin(W'($urandom));
            end else begin
                wr(4'd7, $urandom, 4'($urandom));
            end
            chk("rnd_gpio_o", 32'(gpio_o), m_out);
            chk("rnd_dir_o", 32'(gpio_dir), m_dir);
            chk("rnd_irq", 32'(irq), 32'(m_st != 0));
            rd_chk("rnd_read", 4'($urandom_range(0, 15)));
        end
        rd_chk("rnd_status_final", 4'd7);

        // asynchronous reset while ack is high on a DIR write
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 4'd2; dat_i = 32'hFF; sel = 4'hF;
        tick();
        chk("arst_ack_before", 32'(ack), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_ack_drop", 32'(ack), 32'd0);
        chk("arst_dir_o", 32'(gpio_dir), 32'h00F);
        chk("arst_irq", 32'(irq), 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        model_reset();
        tick_n(2);
        rst = 1'b0;
        tick_n(SETTLE);
        m_in = 32'(gpio);
        rd_chk("arst_rd_dir", 4'd2);
        rd_chk("arst_rd_out", 4'd1);
        rd_chk("arst_rd_din", 4'd0);
        rd_chk("arst_rd_status", 4'd7);

`ifdef GPIO_DEBOUNCE_EN
        // glitch rejection and settling with DEBOUNCE=4
        drive_pin(gpio & ~12'h004);
        wr(4'd8, 32'h4, 4'hF);
        rd_chk("deb_reg", 4'd8);
        gpio[2] = 1'b1;
        tick_n(6);
        gpio[2] = 1'b0;
        tick_n(30);
        rd_chk("deb_glitch", 4'd0);
        gpio[2] = 1'b1;
        tick_n(15 + S);
        m_in = 32'(gpio);
        rd_chk("deb_hold", 4'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
